readpixel: RTL

READPIXEL -- requirements
Module: readpixel

---
 rtl/neopixel_pkg.sv | 32 +++
 rtl/neopixel_sync.sv | 34 +++
 rtl/readpixel.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/neopixel_pkg.sv
// Shared NeoPixel definitions: receiver state encoding, pixel size and default
// line timing used by both the readpixel and writepixel blocks.
package neopixel_pkg;

  localparam int unsigned PIXEL_BITS = 24;

  localparam int unsigned DEF_CLK_HZ         = 12_000_000;
  localparam int unsigned DEF_BIT_THRESH_NS  = 600;
  localparam int unsigned DEF_MAX_HIGH_NS    = 2_000;
  localparam int unsigned DEF_RESET_GAP_NS   = 50_000;
  // Transmit-side pulse shapes for writepixel.
  localparam int unsigned DEF_T0H_NS         = 350;
  localparam int unsigned DEF_T1H_NS         = 700;
  localparam int unsigned DEF_BIT_PERIOD_NS  = 1_250;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_PASS
  } np_state_e;

  // Cycles spanned by ns at the given clock rate, truncated.
  function automatic int unsigned ns_to_cycles(input longint unsigned hz,
                                               input longint unsigned ns);
    longint unsigned c;
    c = hz * ns / 64'd1_000_000_000;
    return c[31:0];
  endfunction

endpackage

// File: rtl/neopixel_sync.sv
// Two-flop synchronizer for the asynchronous data line plus single-cycle
// rise/fall strobes derived from the synchronized level.
module neopixel_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic sync_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour and the chain cannot collapse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= d_in;
      sync_q <= meta;
      sync_d <= sync_q;
    end
  end

  assign d_sync = sync_q;
  assign rise   = sync_q & ~sync_d;
  assign fall   = ~sync_q & sync_d;

endmodule

// File: rtl/readpixel.sv
// NeoPixel receiver: captures the first 24-bit pixel after a reset gap and
// forwards the rest of the frame on d_out.
module readpixel
  import neopixel_pkg::*;
#(
  parameter int unsigned clk_in_rate_hz = DEF_CLK_HZ,
  parameter int unsigned bit_thresh_ns  = DEF_BIT_THRESH_NS,
  parameter int unsigned max_high_ns    = DEF_MAX_HIGH_NS,
  parameter int unsigned reset_gap_ns   = DEF_RESET_GAP_NS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_in,
  output logic [7:0] pixel_g,
  output logic [7:0] pixel_r,
  output logic [7:0] pixel_b,
  output logic       valid,
  output logic       d_out,
  output logic       frame_end,
  output logic       error
);

  localparam int unsigned THRESH   = ns_to_cycles(64'(clk_in_rate_hz), 64'(bit_thresh_ns));
  localparam int unsigned MAX_HIGH = ns_to_cycles(64'(clk_in_rate_hz), 64'(max_high_ns));
  localparam int unsigned GAP      = ns_to_cycles(64'(clk_in_rate_hz), 64'(reset_gap_ns));
  localparam int unsigned CNT_MAX  = (GAP > MAX_HIGH + 1) ? GAP : MAX_HIGH + 1;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam int unsigned BW       = $clog2(PIXEL_BITS);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t        THRESH_C   = CW'(THRESH);
  localparam cnt_t        MAX_HIGH_C = CW'(MAX_HIGH);
  localparam cnt_t        GAP_C      = CW'(GAP);
  localparam cnt_t        ONE_C      = CW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PIXEL_BITS - 1);

  logic d_sync;
  logic d_rise;
  logic d_fall;

  neopixel_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_in   (d_in),
    .d_sync (d_sync),
    .rise   (d_rise),
    .fall   (d_fall)
  );

  np_state_e               state;
  cnt_t                    hcnt;
  cnt_t                    lcnt;
  logic [BW-1:0]           bit_cnt;
  logic [PIXEL_BITS-2:0]   shreg;

  cnt_t                    hcnt_inc;
  cnt_t                    lcnt_inc;
  logic                    bit_val;
  logic [PIXEL_BITS-1:0]   pixel_word;

  // Saturating increments keep long idle or stuck-high lines from wrapping.
  assign hcnt_inc   = (hcnt == '1) ? hcnt : hcnt + ONE_C;
  assign lcnt_inc   = (lcnt == '1) ? lcnt : lcnt + ONE_C;
  assign bit_val    = (hcnt > THRESH_C);
  assign pixel_word = {shreg, bit_val};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SYNC;
      hcnt      <= '0;
      lcnt      <= '0;
      bit_cnt   <= '0;
      // NOTE: the shift register is reset like everything else; it is a handful
      // of flops, not a RAM, and a clean reset keeps partial pixels from leaking.
      shreg     <= '0;
      pixel_g   <= '0;
      pixel_r   <= '0;
      pixel_b   <= '0;
      valid     <= 1'b0;
      d_out     <= 1'b0;
      frame_end <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_end <= 1'b0;
      error     <= 1'b0;
      d_out     <= 1'b0;

      unique case (state)
        ST_SYNC: begin
          if (d_sync) begin
            lcnt <= '0;
          end else begin
            lcnt <= lcnt_inc;
            if (lcnt_inc >= GAP_C) begin
              lcnt  <= '0;
              state <= ST_IDLE;
            end
          end
        end

        ST_IDLE: begin
          // The rise cycle is itself the first high cycle, so counting starts at 1.
          if (d_rise) begin
            hcnt    <= ONE_C;
            bit_cnt <= '0;
            state   <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (d_fall) begin
            shreg <= pixel_word[PIXEL_BITS-2:0];
            lcnt  <= ONE_C;
            if (bit_cnt == LAST_BIT) begin
              pixel_g <= pixel_word[23:16];
              pixel_r <= pixel_word[15:8];
              pixel_b <= pixel_word[7:0];
              valid   <= 1'b1;
              state   <= ST_PASS;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              state   <= ST_LOW;
            end
          end else begin
            hcnt <= hcnt_inc;
            if (hcnt_inc > MAX_HIGH_C) begin
              error <= 1'b1;
              lcnt  <= '0;
              state <= ST_SYNC;
            end
          end
        end

        ST_LOW: begin
          if (d_rise) begin
            hcnt  <= ONE_C;
            state <= ST_HIGH;
          end else begin
            lcnt <= lcnt_inc;
            if (lcnt_inc >= GAP_C) begin
              error <= 1'b1;
              lcnt  <= '0;
              state <= ST_IDLE;
            end
          end
        end

        ST_PASS: begin
          if (d_sync) begin
            lcnt  <= '0;
            d_out <= 1'b1;
          end else begin
            lcnt <= lcnt_inc;
            if (lcnt_inc >= GAP_C) begin
              frame_end <= 1'b1;
              lcnt      <= '0;
              state     <= ST_IDLE;
            end
          end
        end

        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule
